// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_memory_responder_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_2000;

    // RV32 load/store funct3 encodings
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_ACCESS,
        DMEM_RESPOND
    } dmem_state_t;

    // Latched copy of a request; req_* pins are ignored after IDLE
    typedef struct packed {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/data_memory_responder_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and extension for loads.
// Misaligned H uses addr[1] only; W always uses lane 0. The misalign flag
// lets the top reject such accesses when error responses are enabled.
module dmem_lane_align
    import data_memory_responder_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Steer write lanes and pick/extend the loaded lane(s)
    always_comb begin
        byte_en  = 4'b1111;
        wword    = wdata;
        rdata    = rword;
        misalign = 1'b0;
        rshift   = rword >> {addr_lo, 3'b000};
        rbyte    = rshift[7:0];
        rhalf    = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            MEM_B, MEM_BU: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
                rdata   = (size == MEM_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            end
            MEM_H, MEM_HU: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = (size == MEM_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
                misalign = addr_lo[0];
            end
            default: begin
                // W, and undefined sizes treated as W
                misalign = (size == MEM_W) && (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-organised RAM servicing CPU load/store requests
// with WAIT_STATES extra cycles before the array access and one registered
// response pulse per request.
// Optional: define DMEM_ERR_RESP_EN to flag misaligned, out-of-range and
// undefined-size requests via rsp_err (flagged requests have no effect).
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    dmem_state_t      state;
    logic [3:0]       wait_cnt;
    dmem_req_t        req_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [3:0]       byte_en;
    logic [31:0]      wword;
    logic [31:0]      ld_data;
    logic             misalign;
    logic             bad_size;
    logic             flag;
    logic             do_write;

    assign offset   = req_q.addr - BASE_ADDR;
    assign idx      = offset[IDX_W+1:2];
    assign rword    = mem[idx];
    assign bad_size = !(req_q.size inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});

    dmem_lane_align u_align (
        .size     (req_q.size),
        .addr_lo  (req_q.addr[1:0]),
        .wdata    (req_q.wdata),
        .rword    (rword),
        .byte_en  (byte_en),
        .wword    (wword),
        .rdata    (ld_data),
        .misalign (misalign)
    );

`ifdef DMEM_ERR_RESP_EN
    // In range when at/above base and the offset fits the index width
    assign flag = misalign || bad_size || (req_q.addr < BASE_ADDR) ||
                  (offset[31:IDX_W+2] != '0);
`else
    // Out-of-range addresses wrap through index truncation
    assign flag = 1'b0;
`endif

    // Offset low bits and, without error responses, the check terms are unused
    logic unused_ok;
    assign unused_ok = ^{offset[1:0], offset[31:IDX_W+2], misalign, bad_size};

    assign do_write = (state == DMEM_ACCESS) && req_q.write && !flag;

    // Byte-masked array write; gated by reset so an asserted reset blocks it
    always_ff @(posedge clock) begin
        if (do_write && reset) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // Request sequencing and registered response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= DMEM_IDLE;
            wait_cnt  <= 4'd0;
            req_q     <= '0;
            rsp_ready <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        req_q    <= '{write: req_write, size: req_size,
                                      addr: req_addr, wdata: req_wdata};
                        wait_cnt <= WS;
                        state    <= (WS != 4'd0) ? DMEM_WAIT : DMEM_ACCESS;
                    end
                end
                DMEM_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) state <= DMEM_ACCESS;
                end
                DMEM_ACCESS: begin
                    rsp_ready <= 1'b1;
                    rsp_err   <= flag;
                    rsp_rdata <= (req_q.write || flag) ? 32'h0 : ld_data;
                    state     <= DMEM_RESPOND;
                end
                DMEM_RESPOND: begin
                    rsp_ready <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    state     <= DMEM_IDLE;
                end
                default: state <= DMEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a byte-level reference model
// predicts each response when the request is issued; a monitor pops and
// compares whenever rsp_ready is seen.
module tb_data_memory_responder;

    localparam int          DEPTH = 64;
    localparam int          WS    = 1;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_size  = 3'b0;
    logic [31:0] req_addr  = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_memory_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_pulse = 0;
    logic       prev_rdy = 1'b0;
    logic [7:0] mb [0:4*DEPTH-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory as a flat byte array, rules from the access size
    task automatic model(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] off;
        logic [31:0] v;
        int nb, st, wi;
        bit sgn;
        off = a - BASE;
        er  = 1'b0;
`ifdef DMEM_ERR_RESP_EN
        if (a < BASE || off >= 32'(4*DEPTH)) er = 1'b1;
        if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) er = 1'b1;
        if ((sz == 3'd1 || sz == 3'd5) && a[0]) er = 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00) er = 1'b1;
`endif
        case (sz)
            3'd0:    begin nb = 1; st = int'(a[1:0]);   sgn = 1; end
            3'd4:    begin nb = 1; st = int'(a[1:0]);   sgn = 0; end
            3'd1:    begin nb = 2; st = 2 * int'(a[1]); sgn = 1; end
            3'd5:    begin nb = 2; st = 2 * int'(a[1]); sgn = 0; end
            default: begin nb = 4; st = 0;              sgn = 0; end
        endcase
        wi = int'(off[7:2]) % DEPTH;
        rd = 32'h0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) mb[wi*4 + st + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[wi*4 + st + i];
                if (sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                rd = v;
            end
        end
    endtask

    // Present one request (valid left high) and wait for its response pulse
    task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        logic [31:0] rd;
        logic er;
        bit got;
        model(wr, sz, a, wd, rd, er);
        e.rdata = rd;
        e.err   = er;
        e.cyc   = cyc;
        q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (rsp_ready === 1'b1) got = 1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no rsp_ready for addr %h, expected within %0d cycles", a, WS + 2);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic gap(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: pop and compare on every response pulse
    always @(negedge clock) begin
        exp_t e;
        if (rsp_ready === 1'b1) begin
            n_pulse++;
            check("pulse_width", {31'h0, prev_rdy}, 32'h0);
            if (q.size() == 0) begin
                check("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                e = q.pop_front();
                check("rdata", rsp_rdata, e.rdata);
                check("err", {31'h0, rsp_err}, {31'h0, e.err});
                check("latency", 32'(cyc - e.cyc), 32'(WS + 2));
            end
        end
        prev_rdy <= rsp_ready;
    end

    initial begin
        int p0;
        logic [2:0] szs [8];
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_ready", {31'h0, rsp_ready}, 32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_err", {31'h0, rsp_err}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // Pre-zero the array so every word is known to the model
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'd2, BASE + 32'(4*w), 32'h0);
        gap(1);

        issue(1'b1, 3'd2, 32'h2000, 32'hDEAD_BEEF);
        gap(1);
        issue(1'b0, 3'd2, 32'h2000, 32'h0);
        gap(2);

        issue(1'b1, 3'd0, 32'h2005, 32'h0000_0080);
        gap(1);
        issue(1'b0, 3'd0, 32'h2005, 32'h0);
        issue(1'b0, 3'd4, 32'h2005, 32'h0);
        issue(1'b0, 3'd2, 32'h2004, 32'h0);
        gap(1);

        issue(1'b1, 3'd2, 32'h2000, 32'h1122_3344);
        issue(1'b1, 3'd1, 32'h2002, 32'h0000_8001);
        issue(1'b0, 3'd2, 32'h2000, 32'h0);
        issue(1'b0, 3'd1, 32'h2002, 32'h0);
        issue(1'b0, 3'd5, 32'h2002, 32'h0);
        gap(1);

        // Four back-to-back loads with req_valid held high
        p0 = n_pulse;
        issue(1'b0, 3'd2, 32'h2000, 32'h0);
        issue(1'b0, 3'd2, 32'h2004, 32'h0);
        issue(1'b0, 3'd0, 32'h2005, 32'h0);
        issue(1'b0, 3'd5, 32'h2002, 32'h0);
        gap(3);
        check("b2b_pulses", 32'(n_pulse - p0), 32'd4);

        // Reset in the WAIT cycle of a store: no response, no write
        issue(1'b1, 3'd2, 32'h2010, 32'hCAFE_F00D);
        gap(1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 3'd2;
        req_addr  = 32'h2010;
        req_wdata = 32'h1234_5678;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("rst_ready", {31'h0, rsp_ready}, 32'h0);
            check("rst_rdata", rsp_rdata, 32'h0);
            check("rst_err", {31'h0, rsp_err}, 32'h0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        issue(1'b0, 3'd2, 32'h2010, 32'h0);
        gap(1);

        // Misaligned, out-of-range (just below base) and last-word boundary
        issue(1'b0, 3'd2, 32'h2002, 32'h0);
        issue(1'b1, 3'd2, 32'h1FFC, 32'h5555_AAAA);
        issue(1'b0, 3'd2, BASE + 32'(4*DEPTH - 4), 32'h0);
        issue(1'b1, 3'd1, 32'h2007, 32'h0000_ABCD);
        issue(1'b0, 3'd2, 32'h2004, 32'h0);
        issue(1'b0, 3'd7, 32'h2000, 32'h0);
        gap(1);

        // Randomized traffic across the array, all sizes, random gaps
        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), szs[$urandom_range(0, 7)],
                  BASE + 32'($urandom_range(0, 4*DEPTH - 1)), $urandom);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end

        gap(8);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
